// File: rtl/axis_burst_m.sv
// rtl/axis_burst_m.sv - FIFO-fed AXI4-Stream burst master; stall counter under AXIS_BURST_M_STALL_CNT_EN
module axis_burst_m #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 8
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_en,
  output logic                   wr_full,
  output logic [$clog2(DEPTH):0] level,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  output logic                   busy,
  output logic                   finish,
  output logic                   tvalid,
  input  logic                   tready,
  output logic [DATA_W-1:0]      tdata,
  output logic                   tlast
`ifdef AXIS_BURST_M_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [LEN_W-1:0]  remaining;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              start_ok;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign fifo_empty = (count == '0);
  assign wr_full    = (count == (AW+1)'(DEPTH));
  assign level      = count;
  assign push       = wr_en & ~wr_full;

  assign tvalid   = (state == S_SEND) & ~fifo_empty;
  assign tdata    = tvalid ? mem[rd_ptr] : '0;
  assign tlast    = tvalid & (remaining == LEN_W'(1));
  assign pop      = tvalid & tready;
  assign start_ok = (state == S_IDLE) & start & (len != '0);

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      finish    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state     <= S_SEND;
            remaining <= len;
            busy      <= 1'b1;
          end
        end
        S_SEND: begin
          if (pop) begin
            remaining <= remaining - LEN_W'(1);
            if (tlast) begin
              state  <= S_DONE;
              finish <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          finish <= 1'b0;
          busy   <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          finish <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXIS_BURST_M_STALL_CNT_EN
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if (tvalid && !tready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_burst_m.sv
// tb/tb_axis_burst_m.sv - randomized bench for axis_burst_m against a queue-based burst model
module tb_axis_burst_m;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int LEN_W  = 8;

  logic              aclk;
  logic              areset_n;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              wr_full;
  logic [3:0]        level;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              finish;
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
`ifdef AXIS_BURST_M_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  axis_burst_m #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .wr_full  (wr_full),
    .level    (level),
    .start    (start),
    .len      (len),
    .busy     (busy),
    .finish   (finish),
    .tvalid   (tvalid),
    .tready   (tready),
    .tdata    (tdata),
    .tlast    (tlast)
`ifdef AXIS_BURST_M_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  // Reference: queued words, beats still owed, and whether a burst or its finish cycle is live.
  logic [DATA_W-1:0] q[$];
  int                beats_left;
  bit                in_burst;
  bit                finish_due;
  int unsigned       stalls;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    beats_left = 0;
    in_burst   = 1'b0;
    finish_due = 1'b0;
    stalls     = 0;
  endtask

  task automatic check_outputs();
    bit exp_valid;
    exp_valid = in_burst && (q.size() > 0);
    check("tvalid", 64'(tvalid), 64'(exp_valid));
    check("tlast", 64'(tlast), 64'(exp_valid && beats_left == 1));
    if (exp_valid) check("tdata", 64'(tdata), 64'(q[0]));
    check("busy", 64'(busy), 64'(in_burst || finish_due));
    check("finish", 64'(finish), 64'(finish_due));
    check("level", 64'(level), 64'(q.size()));
    check("wr_full", 64'(wr_full), 64'(q.size() == DEPTH));
`ifdef AXIS_BURST_M_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif
  endtask

  task automatic step(input bit we, input logic [DATA_W-1:0] wd, input bit st,
                      input int ln, input bit rdy);
    bit v;
    bit p;
    bit w;
    @(negedge aclk);
    check_outputs();
    wr_en   = we;
    wr_data = wd;
    start   = st;
    len     = LEN_W'(ln);
    tready  = rdy;
    @(posedge aclk);
    v = in_burst && (q.size() > 0);
    p = v && rdy;
    w = we && (q.size() < DEPTH);
    if (v && !rdy && stalls < 32'hFFFF) stalls++;
    if (p) begin
      void'(q.pop_front());
      beats_left--;
    end
    if (w) q.push_back(wd);
    if (finish_due) begin
      finish_due = 1'b0;
    end else if (in_burst) begin
      if (p && beats_left == 0) begin
        in_burst   = 1'b0;
        finish_due = 1'b1;
      end
    end else if (st && ln != 0) begin
      in_burst   = 1'b1;
      beats_left = ln;
      stalls     = 0;
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 0, rdy);
  endtask

  task automatic mid_reset();
    @(negedge aclk);
    wr_en  = 1'b0;
    start  = 1'b0;
    tready = 1'b1;
    #2 areset_n = 1'b0;
    #1;
    model_clear();
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_finish", 64'(finish), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_full", 64'(wr_full), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    @(posedge aclk);
    #2 areset_n = 1'b1;
  endtask

  initial begin
    areset_n = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    start    = 1'b0;
    len      = '0;
    tready   = 1'b0;
    model_clear();
    repeat (3) @(posedge aclk);
    #2;
    check("reset_tdata", 64'(tdata), 64'd0);
    check("reset_level", 64'(level), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    areset_n = 1'b1;

    // Two-word burst, full tready
    step(1'b1, 32'hAAAA_BBBB, 1'b0, 0, 1'b1);
    step(1'b1, 32'hCCCC_DDDD, 1'b0, 0, 1'b1);
    step(1'b0, '0, 1'b1, 2, 1'b1);
    idle(5, 1'b1);

    // Fill past full; the ninth word must be dropped
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    step(1'b0, '0, 1'b1, 8, 1'b1);
    idle(12, 1'b1);

    // Empty FIFO at start, trickle writes; restarts and len=0 must be ignored
    step(1'b0, '0, 1'b1, 0, 1'b1);
    step(1'b0, '0, 1'b1, 3, 1'b1);
    step(1'b0, '0, 1'b1, 5, 1'b1);
    for (int i = 0; i < 14; i++)
      step(i % 4 == 0, 32'h3300_0000 + 32'(i), 1'b0, 0, 1'b1);
    idle(3, 1'b1);

    // Back-pressure while tvalid is high
    step(1'b1, 32'h5555_0001, 1'b0, 0, 1'b0);
    step(1'b1, 32'h5555_0002, 1'b1, 2, 1'b0);
    idle(5, 1'b0);
    idle(5, 1'b1);

    // Reset during the second beat of a four-beat burst, then a clean burst
    for (int i = 0; i < 4; i++) step(1'b1, 32'h4400_0000 + 32'(i), 1'b0, 0, 1'b0);
    step(1'b0, '0, 1'b1, 4, 1'b1);
    step(1'b0, '0, 1'b0, 0, 1'b1);
    mid_reset();
    step(1'b1, 32'h7777_0001, 1'b0, 0, 1'b1);
    step(1'b1, 32'h7777_0002, 1'b1, 2, 1'b1);
    idle(5, 1'b1);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        mid_reset();
      end else begin
        step($urandom_range(0, 99) < 45, $urandom, $urandom_range(0, 99) < 20,
             int'($urandom_range(0, 10)), $urandom_range(0, 99) < 70);
      end
    end
    idle(20, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
